// File: rtl/piloop_mc_if.sv
// Sample, configuration and result signals of the multi-channel PI controller.
// The master side drives samples and config writes; the slave side is the controller.
interface piloop_mc_if #(
    parameter int NCH   = 4,
    parameter int WIN   = 18,
    parameter int WCOEF = 16,
    parameter int WOUT  = 16
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic signed [WIN-1:0]  errin;
    logic [CW-1:0]          chan_in;
    logic                   strobe_in;
    logic                   cfg_we;
    logic [CW-1:0]          cfg_chan;
    logic [2:0]             cfg_sel;
    logic [WCOEF-1:0]       cfg_data;
    logic                   overrun_clr;
    logic signed [WOUT-1:0] ctrl_out;
    logic [CW-1:0]          chan_out;
    logic                   strobe_out;
    logic [NCH-1:0]         open_locked;
    logic                   overrun;

    modport master (
        output errin, chan_in, strobe_in, cfg_we, cfg_chan, cfg_sel, cfg_data, overrun_clr,
        input  ctrl_out, chan_out, strobe_out, open_locked, overrun
    );

    modport slave (
        input  errin, chan_in, strobe_in, cfg_we, cfg_chan, cfg_sel, cfg_data, overrun_clr,
        output ctrl_out, chan_out, strobe_out, open_locked, overrun
    );
endinterface

// File: rtl/piloop_mc.sv
// Time-multiplexed PI controller: one shared 3-stage multiply/accumulate pipeline
// serving NCH independent channels, with output clamping, conditional-integration
// anti-windup and an open-loop tracking preload for bumpless transfer.
module piloop_mc #(
    parameter int NCH   = 4,
    parameter int WIN   = 18,
    parameter int WCOEF = 16,
    parameter int WINTE = 10,
    parameter int WOUT  = 16,
    parameter int PKP   = 6,
    parameter int PKI   = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    piloop_mc_if.slave bus
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int WI = WIN + WCOEF + WINTE;
    localparam int WM = WIN + WCOEF + 1;
    localparam logic signed [WOUT-1:0] OUT_MAX = {1'b0, {(WOUT-1){1'b1}}};
    localparam logic signed [WOUT-1:0] OUT_NMAX = {1'b1, {(WOUT-2){1'b0}}, 1'b1};

    // Saturate a wide signed value to the output width.
    function automatic logic signed [WOUT-1:0] sat_out(input logic signed [WI-1:0] v);
        if ((&v[WI-1:WOUT-1]) || !(|v[WI-1:WOUT-1]))
            sat_out = v[WOUT-1:0];
        else if (v[WI-1])
            sat_out = {1'b1, {(WOUT-1){1'b0}}};
        else
            sat_out = {1'b0, {(WOUT-1){1'b1}}};
    endfunction

    // Per-channel registers
    logic [WCOEF-1:0]       kp_q [NCH], kp_d [NCH];
    logic [WCOEF-1:0]       ki_q [NCH], ki_d [NCH];
    logic signed [WOUT-1:0] ol_q [NCH], ol_d [NCH];
    logic signed [WOUT-1:0] hi_q [NCH], hi_d [NCH];
    logic signed [WOUT-1:0] lo_q [NCH], lo_d [NCH];
    logic [2:0]             mode_q [NCH], mode_d [NCH];
    logic signed [WI-1:0]   inte_q [NCH], inte_d [NCH];

    // Stage A: accepted sample with its coefficient snapshot
    logic                   a_vld_q, a_vld_d;
    logic [CW-1:0]          a_chan_q, a_chan_d;
    logic signed [WIN-1:0]  a_err_q, a_err_d;
    logic [WCOEF-1:0]       a_kp_q, a_kp_d, a_ki_q, a_ki_d;
    logic [2:0]             a_mode_q, a_mode_d;
    logic signed [WOUT-1:0] a_ol_q, a_ol_d, a_hi_q, a_hi_d, a_lo_q, a_lo_d;

    // Stage B: exact products
    logic                   b_vld_q, b_vld_d;
    logic [CW-1:0]          b_chan_q, b_chan_d;
    logic signed [WM-1:0]   b_mp_q, b_mp_d, b_mi_q, b_mi_d;
    logic [2:0]             b_mode_q, b_mode_d;
    logic signed [WOUT-1:0] b_ol_q, b_ol_d, b_hi_q, b_hi_d, b_lo_q, b_lo_d;

    // Outputs
    logic signed [WOUT-1:0] ctrl_q, ctrl_d;
    logic [CW-1:0]          chan_q, chan_d;
    logic                   stb_q, stb_d;
    logic                   ovr_q, ovr_d;
    logic [NCH-1:0]         olk_q, olk_d;

    logic accept;
    logic signed [WCOEF:0]  kps, kis;

    logic signed [WI:0]     isum;
    logic signed [WI-1:0]   cand, mp_ext, preload;
    logic signed [WOUT-1:0] p_term, i_term, clamped;
    logic signed [WOUT:0]   sum;
    logic                   over_hi, under_lo, hold;

    // Config writes, pipeline advance, overrun and open-loop detection
    always_comb begin
        kp_d = kp_q; ki_d = ki_q; ol_d = ol_q; hi_d = hi_q; lo_d = lo_q; mode_d = mode_q;
        if (bus.cfg_we) begin
            case (bus.cfg_sel)
                3'd0: kp_d[bus.cfg_chan] = bus.cfg_data;
                3'd1: ki_d[bus.cfg_chan] = bus.cfg_data;
                3'd2: ol_d[bus.cfg_chan] = bus.cfg_data[WOUT-1:0];
                3'd3: hi_d[bus.cfg_chan] = bus.cfg_data[WOUT-1:0];
                3'd4: lo_d[bus.cfg_chan] = bus.cfg_data[WOUT-1:0];
                3'd5: mode_d[bus.cfg_chan] = bus.cfg_data[2:0];
                default: ;
            endcase
        end

        // A new sample is only taken when neither earlier stage is occupied.
        accept   = bus.strobe_in && !a_vld_q && !b_vld_q;
        ovr_d    = (bus.strobe_in && !accept) ? 1'b1 : (bus.overrun_clr ? 1'b0 : ovr_q);
        a_vld_d  = accept;
        a_chan_d = accept ? bus.chan_in : a_chan_q;
        a_err_d  = accept ? bus.errin : a_err_q;
        a_kp_d   = accept ? kp_q[bus.chan_in] : a_kp_q;
        a_ki_d   = accept ? ki_q[bus.chan_in] : a_ki_q;
        a_mode_d = accept ? mode_q[bus.chan_in] : a_mode_q;
        a_ol_d   = accept ? ol_q[bus.chan_in] : a_ol_q;
        a_hi_d   = accept ? hi_q[bus.chan_in] : a_hi_q;
        a_lo_d   = accept ? lo_q[bus.chan_in] : a_lo_q;

        for (int c = 0; c < NCH; c++)
            olk_d[c] = (kp_q[c] == '0) && (ki_q[c] == '0);
    end

    // Stage 1: sign the coefficients and form the exact products
    always_comb begin
        kps      = a_mode_q[1] ? -$signed({1'b0, a_kp_q}) : $signed({1'b0, a_kp_q});
        kis      = a_mode_q[1] ? -$signed({1'b0, a_ki_q}) : $signed({1'b0, a_ki_q});
        b_vld_d  = a_vld_q;
        b_chan_d = a_vld_q ? a_chan_q : b_chan_q;
        b_mp_d   = a_vld_q ? WM'(kps) * WM'(a_err_q) : b_mp_q;
        b_mi_d   = a_vld_q ? WM'(kis) * WM'(a_err_q) : b_mi_q;
        b_mode_d = a_vld_q ? a_mode_q : b_mode_q;
        b_ol_d   = a_vld_q ? a_ol_q : b_ol_q;
        b_hi_d   = a_vld_q ? a_hi_q : b_hi_q;
        b_lo_d   = a_vld_q ? a_lo_q : b_lo_q;
    end

    // Stages 2-3: integrate, scale, clamp, select output and write back the integrator
    always_comb begin
        isum = (WI+1)'(inte_q[b_chan_q]) + (WI+1)'(b_mi_q);
        if (isum[WI] != isum[WI-1])
            cand = isum[WI] ? {1'b1, {(WI-1){1'b0}}} : {1'b0, {(WI-1){1'b1}}};
        else
            cand = isum[WI-1:0];
        mp_ext   = WI'(b_mp_q);
        p_term   = sat_out(mp_ext >>> PKP);
        i_term   = sat_out(cand >>> PKI);
        sum      = (WOUT+1)'(p_term) + (WOUT+1)'(i_term);
        over_hi  = sum > (WOUT+1)'(b_hi_q);
        under_lo = sum < (WOUT+1)'(b_lo_q);
        // The upper limit wins when the limits are crossed.
        if (over_hi)       clamped = b_hi_q;
        else if (under_lo) clamped = b_lo_q;
        else               clamped = sum[WOUT-1:0];
        hold     = (over_hi && !b_mi_q[WM-1] && (b_mi_q != '0)) || (under_lo && b_mi_q[WM-1]);
        preload  = WI'(b_ol_q) <<< PKI;

        inte_d = inte_q;
        if (b_vld_q) begin
            if (b_mode_q[2])      inte_d[b_chan_q] = '0;
            else if (b_mode_q[0]) inte_d[b_chan_q] = preload;
            else if (!hold)       inte_d[b_chan_q] = cand;
        end

        stb_d  = b_vld_q;
        chan_d = b_vld_q ? b_chan_q : chan_q;
        ctrl_d = b_vld_q ? (b_mode_q[0] ? b_ol_q : clamped) : ctrl_q;
    end

    // State registers; reset aborts any sample in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                kp_q[c] <= '0; ki_q[c] <= '0; ol_q[c] <= '0;
                hi_q[c] <= OUT_MAX; lo_q[c] <= OUT_NMAX;
                mode_q[c] <= '0; inte_q[c] <= '0;
            end
            a_vld_q <= 1'b0; a_chan_q <= '0; a_err_q <= '0; a_kp_q <= '0; a_ki_q <= '0;
            a_mode_q <= '0; a_ol_q <= '0; a_hi_q <= '0; a_lo_q <= '0;
            b_vld_q <= 1'b0; b_chan_q <= '0; b_mp_q <= '0; b_mi_q <= '0;
            b_mode_q <= '0; b_ol_q <= '0; b_hi_q <= '0; b_lo_q <= '0;
            ctrl_q <= '0; chan_q <= '0; stb_q <= 1'b0; ovr_q <= 1'b0; olk_q <= '1;
        end else begin
            kp_q <= kp_d; ki_q <= ki_d; ol_q <= ol_d; hi_q <= hi_d; lo_q <= lo_d;
            mode_q <= mode_d; inte_q <= inte_d;
            a_vld_q <= a_vld_d; a_chan_q <= a_chan_d; a_err_q <= a_err_d;
            a_kp_q <= a_kp_d; a_ki_q <= a_ki_d; a_mode_q <= a_mode_d;
            a_ol_q <= a_ol_d; a_hi_q <= a_hi_d; a_lo_q <= a_lo_d;
            b_vld_q <= b_vld_d; b_chan_q <= b_chan_d; b_mp_q <= b_mp_d; b_mi_q <= b_mi_d;
            b_mode_q <= b_mode_d; b_ol_q <= b_ol_d; b_hi_q <= b_hi_d; b_lo_q <= b_lo_d;
            ctrl_q <= ctrl_d; chan_q <= chan_d; stb_q <= stb_d; ovr_q <= ovr_d; olk_q <= olk_d;
        end
    end

    assign bus.ctrl_out    = ctrl_q;
    assign bus.chan_out    = chan_q;
    assign bus.strobe_out  = stb_q;
    assign bus.overrun     = ovr_q;
    assign bus.open_locked = olk_q;
endmodule

// File: tb/tb_piloop_mc.sv
// Bench for piloop_mc: directed scenarios plus randomized samples and config
// writes, checked against an arithmetic reference model of the PI law.
module tb_piloop_mc;
    localparam int NCH = 4, WIN = 18, WCOEF = 16, WINTE = 10, WOUT = 16, PKP = 6, PKI = 6;
    localparam int WI = WIN + WCOEF + WINTE;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    piloop_mc_if #(.NCH(NCH), .WIN(WIN), .WCOEF(WCOEF), .WOUT(WOUT)) bus();

    piloop_mc #(.NCH(NCH), .WIN(WIN), .WCOEF(WCOEF), .WINTE(WINTE), .WOUT(WOUT),
                .PKP(PKP), .PKI(PKI)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    longint kp_m [NCH], ki_m [NCH], ol_m [NCH], hi_m [NCH], lo_m [NCH], inte_m [NCH];
    int     mode_m [NCH];

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint sat(input longint v, input int w);
        longint mx, mn;
        mx = (64'sd1 <<< (w - 1)) - 1;
        mn = -mx - 1;
        return (v > mx) ? mx : ((v < mn) ? mn : v);
    endfunction

    function automatic longint s16(input longint d);
        logic signed [15:0] t;
        t = d[15:0];
        return longint'(t);
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            kp_m[c] = 0; ki_m[c] = 0; ol_m[c] = 0; hi_m[c] = 32767; lo_m[c] = -32767;
            mode_m[c] = 0; inte_m[c] = 0;
        end
    endfunction

    function automatic void model_cfg(input int ch, input int sel, input longint d);
        case (sel)
            0: kp_m[ch] = d & 65535;
            1: ki_m[ch] = d & 65535;
            2: ol_m[ch] = s16(d);
            3: hi_m[ch] = s16(d);
            4: lo_m[ch] = s16(d);
            5: mode_m[ch] = int'(d & 7);
            default: ;
        endcase
    endfunction

    function automatic longint model_olk();
        longint v = 0;
        for (int c = 0; c < NCH; c++)
            if (kp_m[c] == 0 && ki_m[c] == 0) v = v | (64'd1 << c);
        return v;
    endfunction

    // PI law for one sample: returns the output, updates the integrator
    function automatic longint model_step(input int ch, input longint err);
        longint kps, kis, mp, mi, cand, p, i, s, cl;
        bit     rev, stat, rsti, hold;
        rev  = (mode_m[ch] & 2) != 0;
        stat = (mode_m[ch] & 1) != 0;
        rsti = (mode_m[ch] & 4) != 0;
        kps  = rev ? -kp_m[ch] : kp_m[ch];
        kis  = rev ? -ki_m[ch] : ki_m[ch];
        mp   = kps * err;
        mi   = kis * err;
        cand = sat(inte_m[ch] + mi, WI);
        p    = sat(mp >>> PKP, WOUT);
        i    = sat(cand >>> PKI, WOUT);
        s    = p + i;
        if (s > hi_m[ch])      cl = hi_m[ch];
        else if (s < lo_m[ch]) cl = lo_m[ch];
        else                   cl = s;
        hold = (s > hi_m[ch] && mi > 0) || (s < lo_m[ch] && mi < 0);
        if (rsti)      inte_m[ch] = 0;
        else if (stat) inte_m[ch] = ol_m[ch] * (64'sd1 <<< PKI);
        else if (!hold) inte_m[ch] = cand;
        return stat ? ol_m[ch] : cl;
    endfunction

    // Config write; called and returns at a falling edge
    task automatic cfg_write(input int ch, input int sel, input longint d);
        bus.cfg_we = 1'b1; bus.cfg_chan = 2'(ch); bus.cfg_sel = 3'(sel); bus.cfg_data = d[15:0];
        @(negedge clk);
        bus.cfg_we = 1'b0;
        model_cfg(ch, sel, d);
        $display("cfg   ch=%0d sel=%0d data=%0d", ch, sel, s16(d));
    endtask

    // One sample with full latency check; optionally a write to the same
    // channel lands while the sample is in flight
    task automatic sample(input int ch, input longint err, input bit mid, input int msel,
                          input longint mdata, output longint got);
        longint exp_v;
        exp_v = model_step(ch, err);
        bus.strobe_in = 1'b1; bus.chan_in = 2'(ch); bus.errin = err[17:0];
        @(negedge clk);
        bus.strobe_in = 1'b0;
        if (mid) begin
            bus.cfg_we = 1'b1; bus.cfg_chan = 2'(ch); bus.cfg_sel = 3'(msel);
            bus.cfg_data = mdata[15:0];
        end
        check("stb_t1", longint'(bus.strobe_out), 0);
        @(negedge clk);
        bus.cfg_we = 1'b0;
        if (mid) model_cfg(ch, msel, mdata);
        check("stb_t2", longint'(bus.strobe_out), 0);
        @(negedge clk);
        check("stb_t3", longint'(bus.strobe_out), 1);
        got = longint'($signed(bus.ctrl_out));
        check("ctrl", got, exp_v);
        check("chan", longint'(bus.chan_out), ch);
        check("olk", longint'(bus.open_locked), model_olk());
        $display("smp   ch=%0d err=%0d mid=%0d ctrl=%0d exp=%0d", ch, err, mid, got, exp_v);
    endtask

    longint g;
    longint e1;

    initial begin
        bus.strobe_in = 0; bus.errin = '0; bus.chan_in = '0; bus.cfg_we = 0;
        bus.cfg_chan = '0; bus.cfg_sel = '0; bus.cfg_data = '0; bus.overrun_clr = 0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ctrl", longint'(bus.ctrl_out), 0);
        check("rst_chan", longint'(bus.chan_out), 0);
        check("rst_stb", longint'(bus.strobe_out), 0);
        check("rst_ovr", longint'(bus.overrun), 0);
        check("rst_olk", longint'(bus.open_locked), 15);

        // P only
        cfg_write(0, 0, 64);
        sample(0, 1000, 0, 0, 0, g); check("p_only", g, 1000);

        // Integral ramp with an interleaved idle channel
        cfg_write(1, 1, 64);
        sample(1, 100, 0, 0, 0, g); check("ramp1", g, 100);
        sample(2, 777, 0, 0, 0, g); check("iso_ch2", g, 0);
        sample(1, 100, 0, 0, 0, g); check("ramp2", g, 200);
        sample(2, -555, 0, 0, 0, g); check("iso_ch2b", g, 0);
        sample(1, 100, 0, 0, 0, g); check("ramp3", g, 300);

        // Clamp and anti-windup from a cleared integrator
        cfg_write(1, 5, 4);
        sample(1, 0, 0, 0, 0, g);
        cfg_write(1, 5, 0);
        cfg_write(1, 3, 250);
        sample(1, 100, 0, 0, 0, g); check("clamp1", g, 100);
        sample(1, 100, 0, 0, 0, g); check("clamp2", g, 200);
        sample(1, 100, 0, 0, 0, g); check("clamp3", g, 250);
        sample(1, 100, 0, 0, 0, g); check("clamp4", g, 250);
        sample(1, -100, 0, 0, 0, g); check("unwind", g, 100);

        // Bumpless transfer
        cfg_write(3, 5, 1);
        cfg_write(3, 2, 500);
        cfg_write(3, 0, 64);
        sample(3, 0, 0, 0, 0, g); check("ol_static", g, 500);
        cfg_write(3, 5, 0);
        sample(3, 0, 0, 0, 0, g); check("bumpless", g, 500);
        sample(3, 10, 0, 0, 0, g); check("bump_p", g, 510);

        // Overrun: second strobe two cycles later is dropped
        e1 = model_step(0, 1000);
        bus.strobe_in = 1; bus.chan_in = 2'd0; bus.errin = 18'd1000;
        @(negedge clk); bus.strobe_in = 0;
        @(negedge clk); bus.strobe_in = 1; bus.errin = 18'd5;
        @(negedge clk); bus.strobe_in = 0;
        check("ovr_stb", longint'(bus.strobe_out), 1);
        check("ovr_ctrl", longint'($signed(bus.ctrl_out)), e1);
        check("ovr_flag", longint'(bus.overrun), 1);
        @(negedge clk); check("ovr_drop1", longint'(bus.strobe_out), 0);
        @(negedge clk); check("ovr_drop2", longint'(bus.strobe_out), 0);
        @(negedge clk); check("ovr_drop3", longint'(bus.strobe_out), 0);
        check("ovr_sticky", longint'(bus.overrun), 1);
        bus.overrun_clr = 1;
        @(negedge clk); bus.overrun_clr = 0;
        check("ovr_clr", longint'(bus.overrun), 0);
        $display("ovr   overrun sequence done");

        // Reverse action
        cfg_write(0, 5, 2);
        sample(0, 1000, 0, 0, 0, g); check("reverse", g, -1000);

        // Snapshot: a write in flight only affects the next sample
        sample(0, 1000, 1, 0, 128, g); check("snap_old", g, -1000);
        sample(0, 1000, 0, 0, 0, g); check("snap_new", g, -2000);

        // Randomized phase
        for (int it = 0; it < 150; it++) begin
            int r, ch, sel;
            longint d, err;
            r  = int'($urandom_range(0, 9));
            ch = int'($urandom_range(0, NCH - 1));
            sel = int'($urandom_range(0, 5));
            case (sel)
                0, 1: d = ($urandom_range(0, 3) == 0) ? longint'($urandom_range(0, 65535))
                                                      : longint'($urandom_range(0, 200));
                3:    d = longint'($urandom_range(0, 32767));
                4:    d = -longint'($urandom_range(0, 32767));
                5:    d = ($urandom_range(0, 1) == 0) ? 0 : longint'($urandom_range(0, 7));
                default: d = longint'($urandom_range(0, 65535));
            endcase
            err = ($urandom_range(0, 3) == 0) ? longint'($urandom_range(0, 262143)) - 131072
                                              : longint'($urandom_range(0, 4000)) - 2000;
            if (r < 4) cfg_write(ch, sel, d);
            else sample(ch, err, $urandom_range(0, 4) == 0, sel, d, g);
        end

        // Reset mid-pipeline aborts the sample and clears all state
        cfg_write(1, 5, 0);
        cfg_write(1, 3, 32767);
        cfg_write(1, 1, 64);
        sample(1, 300, 0, 0, 0, g);
        bus.strobe_in = 1; bus.chan_in = 2'd1; bus.errin = 18'd100;
        @(negedge clk); bus.strobe_in = 0;
        rst_n = 0;
        #1;
        model_reset();
        check("arst_ctrl", longint'(bus.ctrl_out), 0);
        check("arst_stb", longint'(bus.strobe_out), 0);
        check("arst_olk", longint'(bus.open_locked), 15);
        @(negedge clk); rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); check("arst_nostb", longint'(bus.strobe_out), 0);
        end
        cfg_write(1, 1, 64);
        sample(1, 0, 0, 0, 0, g); check("arst_inte", g, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
